// File: rtl/ec_scalar_mul_ctrl.sv
// ec_scalar_mul_ctrl: left-to-right double-and-add sequencer for R = k*P.
// Drives one external EC point-add/double core through a start/done handshake and
// resolves point-at-infinity and inverse-point cases locally.
// Optional core watchdog: define EC_SCHED_TIMEOUT_EN (adds the err output).
module ec_scalar_mul_ctrl #(
    parameter int unsigned P_WIDTH     = 6,
    parameter int unsigned K_WIDTH     = 6,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [P_WIDTH-1:0] in_Px,
    input  logic [P_WIDTH-1:0] in_Py,
    input  logic [K_WIDTH-1:0] in_k,
    input  logic [P_WIDTH-1:0] in_prime,
    input  logic [P_WIDTH-1:0] in_a,
    output logic               ec_in_valid,
    output logic [P_WIDTH-1:0] ec_Px,
    output logic [P_WIDTH-1:0] ec_Py,
    output logic [P_WIDTH-1:0] ec_Qx,
    output logic [P_WIDTH-1:0] ec_Qy,
    output logic [P_WIDTH-1:0] ec_prime,
    output logic [P_WIDTH-1:0] ec_a,
    input  logic               ec_out_valid,
    input  logic [P_WIDTH-1:0] ec_Rx,
    input  logic [P_WIDTH-1:0] ec_Ry,
    output logic               busy,
    output logic               out_valid,
    output logic [P_WIDTH-1:0] out_Rx,
    output logic [P_WIDTH-1:0] out_Ry,
    output logic               out_inf
`ifdef EC_SCHED_TIMEOUT_EN
    ,
    output logic               err
`endif
);

    localparam int unsigned IDX_W = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, DBL, DBL_W, ADD, ADD_W, NEXT, DONE
    } state_t;

    state_t             state, next_state;
    logic [P_WIDTH-1:0] px, py, prime_reg, a_reg;
    logic [K_WIDTH-1:0] k_sh;
    logic [IDX_W-1:0]   idx;
    logic [P_WIDTH-1:0] acc_x, acc_y;
    logic               acc_inf;
    logic               issue_c, dbl_c, final_inf_c;

`ifdef EC_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]    wd_cnt;
    logic               timeout_c;
    logic               wd_expired_c;
    assign wd_expired_c = (wd_cnt == TO_W'(TIMEOUT_CYC - 1));
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode, core request decision and watchdog abort
    always_comb begin
        next_state = state;
        issue_c    = 1'b0;
        dbl_c      = 1'b0;
`ifdef EC_SCHED_TIMEOUT_EN
        timeout_c  = 1'b0;
`endif
        case (state)
            IDLE: if (in_valid) next_state = LOAD;
            LOAD: next_state = DBL;
            DBL: begin
                if (!acc_inf && (acc_y != '0)) begin
                    issue_c    = 1'b1;
                    dbl_c      = 1'b1;
                    next_state = DBL_W;
                end else begin
                    next_state = ADD;
                end
            end
            DBL_W: begin
                if (ec_out_valid) next_state = ADD;
`ifdef EC_SCHED_TIMEOUT_EN
                else if (wd_expired_c) begin
                    timeout_c  = 1'b1;
                    next_state = DONE;
                end
`endif
            end
            ADD: begin
                if (k_sh[K_WIDTH-1] && !acc_inf && !((acc_x == px) && (acc_y != py))) begin
                    issue_c    = 1'b1;
                    next_state = ADD_W;
                end else begin
                    next_state = NEXT;
                end
            end
            ADD_W: begin
                if (ec_out_valid) next_state = NEXT;
`ifdef EC_SCHED_TIMEOUT_EN
                else if (wd_expired_c) begin
                    timeout_c  = 1'b1;
                    next_state = DONE;
                end
`endif
            end
            NEXT:    next_state = (idx == '0) ? DONE : DBL;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Result is INF only on a normal finish with an INF accumulator
`ifdef EC_SCHED_TIMEOUT_EN
    assign final_inf_c = acc_inf && !timeout_c;
`else
    assign final_inf_c = acc_inf;
`endif

    // Operand capture, bit walk and accumulator updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px        <= '0;
            py        <= '0;
            prime_reg <= '0;
            a_reg     <= '0;
            k_sh      <= '0;
            idx       <= '0;
            acc_x     <= '0;
            acc_y     <= '0;
            acc_inf   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        px        <= in_Px;
                        py        <= in_Py;
                        prime_reg <= in_prime;
                        a_reg     <= in_a;
                        k_sh      <= in_k;
                    end
                end
                LOAD: begin
                    idx     <= IDX_W'(K_WIDTH - 1);
                    acc_x   <= '0;
                    acc_y   <= '0;
                    acc_inf <= 1'b1;
                end
                DBL: begin
                    if (!acc_inf && (acc_y == '0)) acc_inf <= 1'b1;
                end
                DBL_W, ADD_W: begin
                    if (ec_out_valid) begin
                        acc_x <= ec_Rx;
                        acc_y <= ec_Ry;
                    end
                end
                ADD: begin
                    if (k_sh[K_WIDTH-1]) begin
                        if (acc_inf) begin
                            acc_x   <= px;
                            acc_y   <= py;
                            acc_inf <= 1'b0;
                        end else if ((acc_x == px) && (acc_y != py)) begin
                            acc_inf <= 1'b1;
                        end
                    end
                end
                NEXT: begin
                    if (idx != '0) begin
                        idx  <= idx - IDX_W'(1);
                        k_sh <= k_sh << 1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef EC_SCHED_TIMEOUT_EN
    // Watchdog: counts cycles spent waiting on the core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              wd_cnt <= '0;
        else if (state == DBL_W || state == ADD_W) wd_cnt <= wd_cnt + TO_W'(1);
        else                                     wd_cnt <= '0;
    end
`endif

    // Registered core request, status and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ec_in_valid <= 1'b0;
            ec_Px       <= '0;
            ec_Py       <= '0;
            ec_Qx       <= '0;
            ec_Qy       <= '0;
            ec_prime    <= '0;
            ec_a        <= '0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_Rx      <= '0;
            out_Ry      <= '0;
            out_inf     <= 1'b0;
`ifdef EC_SCHED_TIMEOUT_EN
            err         <= 1'b0;
`endif
        end else begin
            ec_in_valid <= issue_c;
            if (issue_c) begin
                ec_Px    <= acc_x;
                ec_Py    <= acc_y;
                ec_Qx    <= dbl_c ? acc_x : px;
                ec_Qy    <= dbl_c ? acc_y : py;
                ec_prime <= prime_reg;
                ec_a     <= a_reg;
            end
            busy      <= (next_state != IDLE);
            out_valid <= (next_state == DONE);
            out_inf   <= (next_state == DONE) && final_inf_c;
`ifdef EC_SCHED_TIMEOUT_EN
            err       <= timeout_c;
            out_Rx    <= ((next_state == DONE) && !acc_inf && !timeout_c) ? acc_x : '0;
            out_Ry    <= ((next_state == DONE) && !acc_inf && !timeout_c) ? acc_y : '0;
`else
            out_Rx    <= ((next_state == DONE) && !acc_inf) ? acc_x : '0;
            out_Ry    <= ((next_state == DONE) && !acc_inf) ? acc_y : '0;
`endif
        end
    end

endmodule

// File: tb/tb_ec_scalar_mul_ctrl.sv
// Testbench for ec_scalar_mul_ctrl: 3-cycle EC core model, scoreboard of expected
// results computed by repeated point addition on y^2 = x^3 + 2x + 2 mod 17, P=(5,1).
module tb_ec_scalar_mul_ctrl;

    localparam int unsigned PW  = 6;
    localparam int unsigned KW  = 6;
    localparam int unsigned TO  = 64;
    localparam int          PRM = 17;
    localparam int          CA  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [PW-1:0] in_Px, in_Py, in_prime, in_a;
    logic [KW-1:0] in_k;
    logic          ec_in_valid;
    logic [PW-1:0] ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a;
    logic          ec_out_valid;
    logic [PW-1:0] ec_Rx, ec_Ry;
    logic          busy, out_valid, out_inf;
    logic [PW-1:0] out_Rx, out_Ry;
`ifdef EC_SCHED_TIMEOUT_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    ec_scalar_mul_ctrl #(.P_WIDTH(PW), .K_WIDTH(KW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_Px(in_Px), .in_Py(in_Py), .in_k(in_k), .in_prime(in_prime), .in_a(in_a),
        .ec_in_valid(ec_in_valid), .ec_Px(ec_Px), .ec_Py(ec_Py), .ec_Qx(ec_Qx), .ec_Qy(ec_Qy),
        .ec_prime(ec_prime), .ec_a(ec_a), .ec_out_valid(ec_out_valid), .ec_Rx(ec_Rx), .ec_Ry(ec_Ry),
        .busy(busy), .out_valid(out_valid), .out_Rx(out_Rx), .out_Ry(out_Ry), .out_inf(out_inf)
`ifdef EC_SCHED_TIMEOUT_EN
        , .err(err)
`endif
    );

    typedef struct {
        int inf; int x; int y; int calls; int lat; int err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   calls = 0;
    int   done_cnt = 0;
    int   idle_viol = 0;
    logic core_mute = 1'b0;

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int md(input int v, input int p);
        return ((v % p) + p) % p;
    endfunction

    function automatic int inv(input int v, input int p);
        for (int i = 1; i < p; i++) if (md(v * i, p) == 1) return i;
        return 0;
    endfunction

    // General affine point addition including INF, inverse and doubling cases
    task automatic padd(input int x1, input int y1, input int i1, input int x2, input int y2,
                        input int i2, input int p, input int a,
                        output int x3, output int y3, output int i3);
        int l;
        if (i1 != 0) begin x3 = x2; y3 = y2; i3 = i2; return; end
        if (i2 != 0) begin x3 = x1; y3 = y1; i3 = i1; return; end
        if (x1 == x2 && md(y1 + y2, p) == 0) begin x3 = 0; y3 = 0; i3 = 1; return; end
        if (x1 == x2 && y1 == y2) l = md((3 * x1 * x1 + a) * inv(md(2 * y1, p), p), p);
        else                      l = md((y2 - y1) * inv(md(x2 - x1, p), p), p);
        x3 = md(l * l - x1 - x2, p);
        y3 = md(l * (x1 - x3) - y1, p);
        i3 = 0;
    endtask

    // Reference k*P by k repeated additions
    task automatic ref_mul(input int k, output int x, output int y, output int inf);
        int tx, ty, ti;
        x = 0; y = 0; inf = 1;
        for (int i = 0; i < k; i++) begin
            padd(x, y, inf, 5, 1, 0, PRM, CA, tx, ty, ti);
            x = tx; y = ty; inf = ti;
        end
    endtask

    // Core model: 3-cycle latency, aborts on reset, optionally silent
    int core_cnt;
    int core_rx, core_ry, core_ri;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_cnt     <= 0;
            ec_out_valid <= 1'b0;
            ec_Rx        <= '0;
            ec_Ry        <= '0;
        end else begin
            ec_out_valid <= 1'b0;
            if (ec_in_valid && !core_mute) begin
                padd(int'(ec_Px), int'(ec_Py), 0, int'(ec_Qx), int'(ec_Qy), 0,
                     int'(ec_prime), int'(ec_a), core_rx, core_ry, core_ri);
                core_cnt <= 3;
            end else if (core_cnt != 0) begin
                if (core_cnt == 1) begin
                    ec_out_valid <= 1'b1;
                    ec_Rx        <= PW'(core_rx);
                    ec_Ry        <= PW'(core_ry);
                end
                core_cnt <= core_cnt - 1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts core calls and checks results against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            calls = 0;
        end else begin
            if (ec_in_valid) calls++;
            if (!out_valid && (out_Rx != 0 || out_Ry != 0 || out_inf)) idle_viol++;
`ifdef EC_SCHED_TIMEOUT_EN
            if (!out_valid && err) idle_viol++;
`endif
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("out_inf", int'(out_inf), e.inf);
                    check_eq("out_Rx", int'(out_Rx), e.x);
                    check_eq("out_Ry", int'(out_Ry), e.y);
                    if (e.calls >= 0) check_eq("core_calls", calls, e.calls);
                    if (e.lat >= 0)   check_eq("latency", cyc - start_cyc, e.lat);
`ifdef EC_SCHED_TIMEOUT_EN
                    check_eq("err", int'(err), e.err);
`endif
                end
                calls = 0;
                done_cnt++;
            end
        end
    end

    task automatic start_op(input int k, input int exp_calls, input int exp_lat, input int exp_err);
        exp_t n;
        int   x, y, inf;
        for (int i = 0; i < 500 && busy; i++) @(negedge clk);
        if (busy) check_eq("idle_wait_timeout", 1, 0);
        ref_mul(k, x, y, inf);
        if (exp_err != 0) begin x = 0; y = 0; inf = 0; end
        n.inf = inf; n.x = x; n.y = y; n.calls = exp_calls; n.lat = exp_lat; n.err = exp_err;
        sb.push_back(n);
        @(negedge clk);
        in_k      = KW'(k);
        in_valid  = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
        if (done_cnt == d0) check_eq("done_timeout", 1, 0);
    endtask

    task automatic run_op(input int k, input int exp_calls, input int exp_lat);
        int d0;
        d0 = done_cnt;
        start_op(k, exp_calls, exp_lat, 0);
        wait_done(d0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int d0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_Px    = PW'(5);
        in_Py    = PW'(1);
        in_prime = PW'(PRM);
        in_a     = PW'(CA);
        in_k     = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_ec_in_valid", int'(ec_in_valid), 0);
        check_eq("rst_out_inf", int'(out_inf), 0);
        check_eq("rst_ec_Px", int'(ec_Px), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(0, 0, 20);
        run_op(1, 0, -1);
        run_op(3, 2, -1);
        run_op(18, 5, -1);
        run_op(19, 5, -1);
        run_op(2, 1, -1);
        run_op(45, -1, -1);
        run_op(63, -1, -1);

        // in_valid while busy must be ignored
        d0 = done_cnt;
        start_op(3, 2, -1, 0);
        repeat (4) @(negedge clk);
        check_eq("busy_mid_op", int'(busy), 1);
        in_k = KW'(5);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("busy_after_ignored", int'(busy), 1);
        wait_done(d0);
        repeat (3) @(negedge clk);
        check_eq("no_extra_op", done_cnt, d0 + 1);

        // Reset in DBL_W, then a clean k=2 run
        start_op(3, 2, -1, 0);
        for (int i = 0; i < 200 && !ec_in_valid; i++) @(negedge clk);
        check_eq("saw_core_req", int'(ec_in_valid), 1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_drops_ec_in_valid", int'(ec_in_valid), 0);
        check_eq("rst_drops_busy", int'(busy), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2, 1, -1);

`ifdef EC_SCHED_TIMEOUT_EN
        // Silent core: watchdog abort then a normal operation
        core_mute = 1'b1;
        d0 = done_cnt;
        start_op(3, 1, -1, 1);
        wait_done(d0);
        core_mute = 1'b0;
        run_op(3, 2, -1);
`endif

        repeat (3) @(negedge clk);
        check_eq("sb_empty", sb.size(), 0);
        check_eq("idle_outputs_zero", idle_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
